present_serial_round_ctrl: RTL

//  Nibble-serial PRESENT-80 encryption controller built around the 4-bit S-box/key-add stage (out = S(state) ^ key).

---
 rtl/present_serial_round_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/present_serial_round_ctrl.sv
// present_serial_round_ctrl
//   Nibble-serial PRESENT-80 encryption controller. One state nibble and one
//   key nibble are sent per cycle to an external 4-bit S-box/key-add stage.
//   That stage returns S(state) ^ key in the same cycle, and the result is
//   written back. The pLayer is applied once per round, and the key schedule
//   runs locally.
//
// Ports
//   clock          : rising-edge clock
//   reset          : asynchronous, active-low reset
//   io_in_valid    : plaintext/key presented
//   io_in_ready    : high only while idle
//   io_in_pt       : 64-bit plaintext
//   io_in_key      : 80-bit master key
//   io_out_valid   : high only while the ciphertext is held
//   io_out_ready   : consumer accepts the ciphertext
//   io_out_ct      : 64-bit ciphertext, 0 unless io_out_valid
//   io_sbox_state  : state nibble to the S-box stage, 0 outside RUN
//   io_sbox_key    : key nibble to the S-box stage, 0 outside RUN
//   io_sbox_out    : S(io_sbox_state) ^ io_sbox_key from the stage
module present_serial_round_ctrl #(
  parameter int unsigned ROUNDS = 31,
  parameter int unsigned RCNT_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [63:0] io_in_pt,
  input  logic [79:0] io_in_key,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [63:0] io_out_ct,
  output logic [3:0]  io_sbox_state,
  output logic [3:0]  io_sbox_key,
  input  logic [3:0]  io_sbox_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  fsm_t              r_fsm;
  fsm_t              w_fsm_nx;
  logic [63:0]       r_state;
  logic [79:0]       r_key;
  logic [RCNT_W-1:0] r_round;
  logic [3:0]        r_nib;

  logic              w_accept;
  logic              w_last;
  logic [RCNT_W:0]   w_round_inc;
  logic [63:0]       w_state_wr;
  logic [63:0]       w_kperm;
  logic [5:0]        w_nib_base;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Bit j moves to bit 16j mod 63, and bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 63; j++) begin
      y[(16 * j) % 63] = x[j];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Inverse pLayer: output bit j is taken from input bit P(j).
  function automatic logic [63:0] p_inv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned j = 0; j < 63; j++) begin
      y[j] = x[(16 * j) % 63];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};   // rotate left by 61
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  assign w_accept    = (r_fsm == ST_IDLE) && io_in_valid;
  assign w_last      = (r_fsm == ST_RUN) && (r_nib == 4'hF);
  assign w_round_inc = {1'b0, r_round} + 1'b1;
  assign w_nib_base  = {r_nib, 2'b00};

  // The round key is pre-permuted by P^-1, so the nibble-wise key add done
  // before the pLayer equals the standard key add done after it.
  assign w_kperm = p_inv(r_key[79:16]);

  always_comb begin
    w_state_wr                 = r_state;
    w_state_wr[w_nib_base +: 4] = io_sbox_out;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nx;
    end
  end

  always_comb begin
    w_fsm_nx      = r_fsm;
    io_in_ready   = 1'b0;
    io_out_valid  = 1'b0;
    io_out_ct     = '0;
    io_sbox_state = '0;
    io_sbox_key   = '0;
    case (r_fsm)
      ST_IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          w_fsm_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        io_sbox_state = r_state[w_nib_base +: 4];
        io_sbox_key   = w_kperm[w_nib_base +: 4];
        if (w_last && (r_round == RCNT_W'(ROUNDS))) begin
          w_fsm_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        io_out_valid = 1'b1;
        io_out_ct    = r_state;
        if (io_out_ready) begin
          w_fsm_nx = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
      r_key   <= '0;
      r_round <= '0;
      r_nib   <= '0;
    end else if (w_accept) begin
      r_state <= io_in_pt ^ io_in_key[79:16];
      r_key   <= key_upd(io_in_key, 5'd1);
      r_round <= RCNT_W'(1);
      r_nib   <= '0;
    end else if (w_last) begin
      r_state <= p_layer(w_state_wr);
      r_key   <= key_upd(r_key, w_round_inc[4:0]);
      r_round <= w_round_inc[RCNT_W-1:0];
      r_nib   <= '0;
    end else if (r_fsm == ST_RUN) begin
      r_state <= w_state_wr;
      r_nib   <= r_nib + 4'd1;
    end
  end

endmodule
